// File: rtl/calc_operand_sequencer_if.sv
// Byte command, calculator operand and result handshake bundle
// for the calculator operand sequencer.
interface calc_operand_sequencer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  first_num;
    logic [7:0]  second_num;
    logic [1:0]  operation;
    logic [15:0] calc_result;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_err;
    logic        res_ready;
    logic        busy;

    modport master (
        output in_valid, in_data, calc_result, res_ready,
        input  in_ready, first_num, second_num, operation,
        input  res_valid, res_data, res_err, busy
    );

    modport slave (
        input  in_valid, in_data, calc_result, res_ready,
        output in_ready, first_num, second_num, operation,
        output res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/calc_operand_sequencer.sv
// Collects opcode/A/B bytes, drives the registered calculator,
// waits out its latency and returns the 16-bit result.
module calc_operand_sequencer #(
    parameter int unsigned LATENCY = 1
) (
    input logic                     clk,
    input logic                     reset,
    calc_operand_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        GET_OP,
        GET_A,
        GET_B,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] res_q, res_d;
    logic        err_q, err_d;
    logic        vld_q, vld_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        xfer;

    // in_ready depends on state only, never on res_ready or in_valid
    assign bus.in_ready = (state_q == GET_OP) ||
                          (state_q == GET_A)  ||
                          (state_q == GET_B);
    assign xfer           = bus.in_valid && bus.in_ready;
    assign bus.busy       = (state_q != GET_OP);
    assign bus.first_num  = a_q;
    assign bus.second_num = b_q;
    assign bus.operation  = op_q;
    assign bus.res_valid  = vld_q;
    assign bus.res_data   = res_q;
    assign bus.res_err    = err_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            GET_OP: if (xfer) begin
                op_d    = bus.in_data[1:0];
                state_d = GET_A;
            end
            GET_A: if (xfer) begin
                a_d     = bus.in_data;
                state_d = GET_B;
            end
            GET_B: if (xfer) begin
                // divide-by-zero never reaches the calculator
                if (op_q == 2'b11 && bus.in_data == 8'h00) begin
                    b_d     = 8'h00;
                    res_d   = 16'hFFFF;
                    err_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    b_d     = bus.in_data;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = bus.calc_result;
                    err_d   = 1'b0;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (bus.res_ready) begin
                vld_d   = 1'b0;
                err_d   = 1'b0;
                state_d = GET_OP;
            end
            default: state_d = GET_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GET_OP;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            op_q    <= 2'b00;
            res_q   <= 16'h0000;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed plus random command bench with a registered calculator
// model and an arithmetic reference for expected results.
module tb_calc_operand_sequencer;

    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    calc_operand_sequencer_if bus ();

    calc_operand_sequencer #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // single-register calculator sharing clk and reset
    always @(posedge clk) begin
        if (reset) bus.calc_result <= 16'h0000;
        else begin
            case (bus.operation)
                2'b00: bus.calc_result <= {8'h00, bus.first_num} + {8'h00, bus.second_num};
                2'b01: bus.calc_result <= {8'h00, bus.first_num} - {8'h00, bus.second_num};
                2'b10: bus.calc_result <= bus.first_num * bus.second_num;
                default: bus.calc_result <= (bus.second_num == 0) ? 16'hFFFF :
                                            {8'h00, bus.first_num / bus.second_num};
            endcase
        end
    end

    function automatic logic [16:0] ref_res(input logic [1:0] op,
                                            input int a, input int b);
        int r;
        if (op == 2'b11 && b == 0) return {1'b1, 16'hFFFF};
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: r = a * b;
            default: r = a / b;
        endcase
        return {1'b0, 16'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, bus.res_valid, 0);
        chk({tag, "_data"}, bus.res_data, 0);
        chk({tag, "_err"}, bus.res_err, 0);
        chk({tag, "_a"}, bus.first_num, 0);
        chk({tag, "_b"}, bus.second_num, 0);
        chk({tag, "_op"}, bus.operation, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ready"}, bus.in_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", n, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h5A;
    endtask

    task automatic idle(input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            chk("gap_ready", bus.in_ready, 1);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, input int gap,
                           input int hold);
        logic [16:0] e;
        int k;
        int n;
        e = ref_res(op, a, b);
        bus.res_ready = (hold == 0);
        send_byte({6'h2A, op});
        idle(gap);
        send_byte(a);
        idle(gap);
        send_byte(b);
        k = cyc;
        n = 0;
        while (!bus.res_valid && n < 40) begin
            chk("wait_in_ready", bus.in_ready, 0);
            chk("wait_busy", bus.busy, 1);
            @(negedge clk);
            n++;
        end
        chk("res_valid_seen", bus.res_valid, 1);
        chk("latency", cyc - k, e[16] ? 0 : LAT + 1);
        chk("res_data", bus.res_data, e[15:0]);
        chk("res_err", bus.res_err, e[16]);
        chk("op_held", bus.operation, op);
        chk("a_held", bus.first_num, a);
        chk("b_held", bus.second_num, e[16] ? 8'h00 : b);
        chk("resp_in_ready", bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hC3;
            @(negedge clk);
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_data", bus.res_data, e[15:0]);
            chk("bp_err", bus.res_err, e[16]);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", bus.res_valid, 0);
        chk("post_err", bus.res_err, 0);
        chk("post_in_ready", bus.in_ready, 1);
        chk("post_busy", bus.busy, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;

        run_cmd(2'b00, 8'hC8, 8'h64, 0, 0);
        chk("add_literal", bus.res_data, 16'h012C);
        run_cmd(2'b01, 8'h05, 8'h0A, 0, 0);
        chk("sub_literal", bus.res_data, 16'hFFFB);
        run_cmd(2'b10, 8'hFF, 8'hFF, 0, 0);
        chk("mul_literal", bus.res_data, 16'hFE01);
        run_cmd(2'b11, 8'h64, 8'h07, 0, 0);
        run_cmd(2'b11, 8'h64, 8'h00, 0, 0);
        run_cmd(2'b10, 8'h12, 8'h34, 0, 5);
        run_cmd(2'b00, 8'h01, 8'h02, 3, 0);
        chk("bubble_literal", bus.res_data, 16'h0003);

        // reset while waiting on the calculator
        send_byte(8'h02);
        send_byte(8'h09);
        send_byte(8'h07);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("rst_wait");

        // reset after only the opcode byte
        send_byte(8'h03);
        chk("opc_taken", bus.operation, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("rst_opc");
        run_cmd(2'b00, 8'h10, 8'h20, 0, 0);
        chk("after_rst", bus.res_data, 16'h0030);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic [7:0] a;
            logic [7:0] b;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_cmd(op, a, b, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
